// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the half-precision datapath (encode, decode,
// exception and normalize blocks).
//   FP16_BIAS     exponent bias
//   FP16_EXP_W    exponent field width
//   FP16_MANT_W   mantissa field width
//   FP16_EXP_INF  all-ones exponent (infinity / NaN)
//   FP16_QNAN     canonical quiet NaN
//   enc_state_t   integer-encoder FSM states
package fp16_pkg;

    localparam int unsigned FP16_BIAS    = 15;
    localparam int unsigned FP16_EXP_W   = 5;
    localparam int unsigned FP16_MANT_W  = 10;
    localparam logic [4:0]  FP16_EXP_INF = 5'h1F;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } enc_state_t;

endpackage

// File: rtl/fp16_int_encode_if.sv
// Request/result handshake bundle for the integer-to-FP16 encoder.
//   in_valid/in_ready/in_int         request channel
//   out_valid/out_ready/q/out_inexact result channel
// slave modport is the encoder side; master modport is the producer/consumer.
interface fp16_int_encode_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_int;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        out_inexact;

    modport slave (
        input  in_valid,
        input  in_int,
        input  out_ready,
        output in_ready,
        output out_valid,
        output q,
        output out_inexact
    );

    modport master (
        output in_valid,
        output in_int,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  q,
        input  out_inexact
    );

endinterface

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and FP16 packing of a normalized magnitude.
//   sign     result sign
//   exp      biased exponent matching mag (mag[15] is the hidden one)
//   mag      normalized 16-bit magnitude, mag[15]==1
//   q        packed binary16 {sign, exp, mant}
//   inexact  result differs from the exact value (rounded or overflowed)
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic        sign,
    input  logic [4:0]  exp,
    input  logic [15:0] mag,
    output logic [15:0] q,
    output logic        inexact
);

    logic [9:0]  mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [10:0] mant_sum;
    logic [4:0]  exp_r;
    logic        unused_msb;

    // The hidden bit is implied by normalization.
    assign unused_msb = mag[15];

    always_comb begin
        mant     = mag[14:5];
        guard    = mag[4];
        sticky   = |mag[3:0];
        round_up = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {10'd0, round_up};
        // Mantissa carry-out renormalizes by bumping the exponent; mant_sum[9:0]
        // is already zero in that case. Max exp is 30, so this never wraps.
        exp_r    = exp + {4'd0, mant_sum[10]};

        if (exp_r == FP16_EXP_INF) begin
            q       = {sign, FP16_EXP_INF, 10'd0};
            inexact = 1'b1;
        end else begin
            q       = {sign, exp_r, mant_sum[9:0]};
            inexact = guard | sticky;
        end
    end

endmodule

// File: rtl/fp16_int_encode.sv
// Sequential integer-to-FP16 encoder: takes a 16-bit integer over a valid/ready
// handshake, normalizes it one bit per cycle, rounds to nearest-even and
// returns an IEEE-754 binary16 word.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    request/result handshake (slave side)
// SIGNED_IN: 1 = in_int is two's complement, 0 = in_int is unsigned.
module fp16_int_encode
    import fp16_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp16_int_encode_if.slave     bus
);

    // Biased exponent of an integer whose MSB sits at bit 15.
    localparam logic [4:0] EXP_START = 5'(FP16_BIAS + 15);

    enc_state_t  state_q, state_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [4:0]  exp_q, exp_d;
    logic [15:0] q_q, q_d;
    logic        inexact_q, inexact_d;

    logic        in_sign;
    logic [15:0] in_mag;
    logic [15:0] pack_q;
    logic        pack_inexact;

    // 0x8000 negates to itself, which is the correct unsigned magnitude.
    assign in_sign = SIGNED_IN & bus.in_int[15];
    assign in_mag  = in_sign ? (~bus.in_int) + 16'd1 : bus.in_int;

    fp16_round_pack u_round_pack (
        .sign    (sign_q),
        .exp     (exp_q),
        .mag     (mag_q),
        .q       (pack_q),
        .inexact (pack_inexact)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        q_d       = q_q;
        inexact_d = inexact_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = in_sign;
                    mag_d  = in_mag;
                    exp_d  = EXP_START;
                    if (in_mag == 16'd0) begin
                        // Zero always encodes as +0, even for signed input.
                        q_d       = 16'h0000;
                        inexact_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[15]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    exp_d = exp_q - 5'd1;
                end
            end
            ROUND: begin
                q_d       = pack_q;
                inexact_d = pack_inexact;
                state_d   = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= 16'd0;
            exp_q     <= 5'd0;
            q_q       <= 16'd0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            q_q       <= q_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.q           = q_q;
    assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_fp16_int_encode.sv
module tb_fp16_int_encode;

    logic clk;
    logic rst_n;

    fp16_int_encode_if ifs ();
    fp16_int_encode_if ifu ();

    fp16_int_encode #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs)
    );

    fp16_int_encode #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    typedef struct {
        bit          sgn;
        logic [15:0] din;
        logic [15:0] q;
        bit          inexact;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sel_out_valid(input bit sel);
        return sel ? ifs.out_valid : ifu.out_valid;
    endfunction

    // Present one request at a negedge; returns #1 after the accepting edge.
    task automatic start_req(input bit sel, input logic [15:0] din);
        @(negedge clk);
        if (sel) begin
            ifs.in_valid = 1'b1;
            ifs.in_int   = din;
        end else begin
            ifu.in_valid = 1'b1;
            ifu.in_int   = din;
        end
        @(posedge clk);
        #1;
        ifs.in_valid = 1'b0;
        ifu.in_valid = 1'b0;
        ifs.in_int   = 16'hDEAD;
        ifu.in_int   = 16'hDEAD;
    endtask

    // Counts cycles after accept until out_valid is seen at a negedge.
    task automatic wait_out(input bit sel, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (sel_out_valid(sel)) break;
            if (lat >= 40) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout: out_valid not seen within 40 cycles");
                break;
            end
        end
    endtask

    task automatic release_out();
        ifs.out_ready = 1'b1;
        ifu.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifs.out_ready = 1'b0;
        ifu.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_req(v.sgn, v.din);
        wait_out(v.sgn, lat);
        check($sformatf("q[%h]", v.din), v.sgn ? ifs.q : ifu.q, v.q);
        check($sformatf("inexact[%h]", v.din),
              v.sgn ? ifs.out_inexact : ifu.out_inexact, v.inexact);
        check($sformatf("latency[%h]", v.din), lat, v.lat);
        release_out();
    endtask

    initial begin
        int lat;
        bit seen;
        n_vec = 0;
        n_err = 0;

        //          sgn  din       q         inx  lat
        vecs[0]  = '{1'b1, 16'h0001, 16'h3C00, 1'b0, 18};
        vecs[1]  = '{1'b1, 16'h8000, 16'hF800, 1'b0, 3};
        vecs[2]  = '{1'b1, 16'h0801, 16'h6800, 1'b1, 7};   // 2049 tie -> even
        vecs[3]  = '{1'b1, 16'h0803, 16'h6802, 1'b1, 7};   // 2051 tie -> up
        vecs[4]  = '{1'b1, 16'hF800, 16'hE800, 1'b0, 7};   // -2048
        vecs[5]  = '{1'b0, 16'hFFE0, 16'h7BFF, 1'b0, 3};   // 65504
        vecs[6]  = '{1'b0, 16'hFFFF, 16'h7C00, 1'b1, 3};   // overflow -> inf
        vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[8]  = '{1'b1, 16'hFFFF, 16'hBC00, 1'b0, 18};  // -1
        vecs[9]  = '{1'b0, 16'h8000, 16'h7800, 1'b0, 3};   // 32768 unsigned
        vecs[10] = '{1'b1, 16'h7FFF, 16'h7800, 1'b1, 4};   // mantissa carry
        vecs[11] = '{1'b0, 16'h0003, 16'h4200, 1'b0, 17};

        rst_n         = 1'b0;
        ifs.in_valid  = 1'b0;
        ifs.in_int    = 16'h0;
        ifs.out_ready = 1'b0;
        ifu.in_valid  = 1'b0;
        ifu.in_int    = 16'h0;
        ifu.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", ifs.in_ready, 1'b1);
        check("rst_out_valid", ifs.out_valid, 1'b0);
        check("rst_q", ifs.q, 16'h0000);
        check("rst_inexact", ifs.out_inexact, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Zero result held under back-pressure while a new request waits.
        start_req(1'b1, 16'h0000);
        wait_out(1'b1, lat);
        check("zero_lat", lat, 1);
        check("zero_q", ifs.q, 16'h0000);
        ifs.in_valid = 1'b1;
        ifs.in_int   = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", ifs.out_valid, 1'b1);
            check("hold_in_ready", ifs.in_ready, 1'b0);
            check("hold_q", ifs.q, 16'h0000);
        end
        ifs.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifs.out_ready = 1'b0;
        @(negedge clk);
        check("after_rel_in_ready", ifs.in_ready, 1'b1);
        check("after_rel_out_valid", ifs.out_valid, 1'b0);
        @(posedge clk);
        #1;
        ifs.in_valid = 1'b0;
        wait_out(1'b1, lat);
        check("queued_lat", lat, 17);
        check("queued_q", ifs.q, 16'h4200);
        release_out();

        // Reset mid-normalization aborts the operation.
        start_req(1'b1, 16'h0003);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", ifs.out_valid, 1'b0);
        check("abort_q", ifs.q, 16'h0000);
        check("abort_in_ready", ifs.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ifs.out_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 1'b0);
        start_req(1'b1, 16'h0003);
        wait_out(1'b1, lat);
        check("post_abort_q", ifs.q, 16'h4200);
        check("post_abort_lat", lat, 17);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
